hornet_stack: RTL and testbench

//  Circular LIFO that backs one Hornet core stack: one instance for the data stack, one for the return stack.
//  - Core spills its S (or R) register into the block with a push.
//  - Core takes q back through dsq (or rsq) with a pop.
//  - Like F18-style stacks, the buffer never blocks: it wraps silently, overwriting the oldest entry.

---
 rtl/hornet_stack.sv | 120 ++++++++++++
 tb/tb_hornet_stack.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hornet_stack.sv
// hornet_stack: circular LIFO backing one Hornet core stack (data or return).
// Pushes spill the core's S/R register into the buffer and pops expose the
// entry below through q. The buffer never blocks: the pointer wraps modulo
// DEPTH in both directions, silently overwriting the oldest entry on
// overflow and returning stale or wrapped data on underflow.
//
// Optional feature: define HORNET_STACK_WATERMARK_EN to build the saturating
// fill counter (depth) and the sticky ovf/unf flags with their clr input.
// Without it those outputs are tied low, clr is ignored, and no counter
// logic is built.
module hornet_stack #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         d,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    wr_ptr;
  logic             wr_en;

  // Decode the strobes: push-only writes one above the top, pop-only steps
  // down, push+pop replaces the top in place.
  always_comb begin
    ptr_nxt = ptr;
    wr_ptr  = ptr;
    wr_en   = 1'b0;
    case ({push, pop})
      2'b10: begin
        ptr_nxt = ptr + 1'b1;
        wr_ptr  = ptr + 1'b1;
        wr_en   = 1'b1;
      end
      2'b01: begin
        ptr_nxt = ptr - 1'b1;
      end
      2'b11: begin
        wr_en   = 1'b1;
      end
      default: begin
        ptr_nxt = ptr;
      end
    endcase
  end

  // Pointer and storage; reset clears every entry so q reads 0 immediately
  // and any in-flight push is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      ptr <= ptr_nxt;
      if (wr_en) begin
        mem[wr_ptr] <= d;
      end
    end
  end

  // Zero-latency read: the core samples the top in the same cycle it pops.
  assign q = mem[ptr];

`ifdef HORNET_STACK_WATERMARK_EN
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  function automatic logic [PW:0] sat_inc(input logic [PW:0] cnt);
    return (cnt == FULL) ? cnt : cnt + 1'b1;
  endfunction

  function automatic logic [PW:0] sat_dec(input logic [PW:0] cnt);
    return (cnt == '0) ? cnt : cnt - 1'b1;
  endfunction

  // Saturating fill count with sticky flags; clr beats any same-cycle set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (clr) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push && !pop) begin
      if (depth == FULL) begin
        ovf <= 1'b1;
      end
      depth <= sat_inc(depth);
    end else if (pop && !push) begin
      if (depth == '0) begin
        unf <= 1'b1;
      end
      depth <= sat_dec(depth);
    end
  end
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign depth      = '0;
  assign ovf        = 1'b0;
  assign unf        = 1'b0;
`endif

endmodule

// File: tb/tb_hornet_stack.sv
// tb_hornet_stack: directed bench for hornet_stack. A behavioural model
// (an unbounded top-of-stack counter over a DEPTH-slot ring, plus a clamped
// fill count) tracks the expected outputs and is compared on every falling
// edge; hand-computed literals pin the model at key points.
module tb_hornet_stack;

  localparam int W   = 18;
  localparam int DEP = 8;
  localparam int DW  = $clog2(DEP) + 1;
`ifdef HORNET_STACK_WATERMARK_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          push;
  logic          pop;
  logic          clr;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic [DW-1:0] depth;
  logic          ovf;
  logic          unf;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [W-1:0] m_mem [DEP];
  int           m_top;
  int           m_cnt;
  bit           m_ovf;
  bit           m_unf;

  hornet_stack #(.WIDTH(W), .DEPTH(DEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .clr     (clr),
    .d       (d),
    .q       (q),
    .depth   (depth),
    .ovf     (ovf),
    .unf     (unf)
  );

  always #5 clk = ~clk;

  function automatic int slot(input int t);
    return ((t % DEP) + DEP) % DEP;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) m_mem[i] = '0;
    m_top = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_apply(input bit p, input bit o, input bit c, input logic [W-1:0] dd);
    if (p && !o) begin
      m_top = m_top + 1;
      m_mem[slot(m_top)] = dd;
    end else if (p && o) begin
      m_mem[slot(m_top)] = dd;
    end else if (o) begin
      m_top = m_top - 1;
    end
    if (c) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (p && !o) begin
      if (m_cnt == DEP) m_ovf = 1'b1;
      else m_cnt = m_cnt + 1;
    end else if (o && !p) begin
      if (m_cnt == 0) m_unf = 1'b1;
      else m_cnt = m_cnt - 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model q", 32'(q), 32'(m_mem[slot(m_top)]));
      check("model depth", 32'(depth), WM ? 32'(m_cnt) : 32'd0);
      check("model ovf", 32'(ovf), WM ? 32'(m_ovf) : 32'd0);
      check("model unf", 32'(unf), WM ? 32'(m_unf) : 32'd0);
    end
  end

  // One operation per call; called and returning just after a rising edge
  task automatic op(input bit p, input bit o, input bit c, input logic [W-1:0] dd);
    push = p;
    pop  = o;
    clr  = c;
    d    = dd;
    @(posedge clk);
    model_apply(p, o, c, dd);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] exp2 [8];
    exp2 = '{18'd8, 18'd7, 18'd6, 18'd5, 18'd4, 18'd3, 18'd2, 18'd9};
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
    d    = '0;
    chk_en = 1'b1;
    do_reset();
    check("reset q", 32'(q), 32'd0);
    check("reset depth", 32'(depth), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);

    // 1: push three, pop three
    op(1, 0, 0, 18'h00011); check("t1 push1", 32'(q), 32'h11);
    op(1, 0, 0, 18'h00022); check("t1 push2", 32'(q), 32'h22);
    op(1, 0, 0, 18'h00033); check("t1 push3", 32'(q), 32'h33);
    op(0, 1, 0, '0);        check("t1 pop1", 32'(q), 32'h22);
    op(0, 1, 0, '0);        check("t1 pop2", 32'(q), 32'h11);
    op(0, 1, 0, '0);        check("t1 pop3", 32'(q), 32'h0);

    // 2: wrap on the ninth push
    do_reset();
    for (int v = 1; v <= 9; v++) op(1, 0, 0, W'(v));
    check("t2 top", 32'(q), 32'd9);
    for (int i = 0; i < 8; i++) begin
      op(0, 1, 0, '0);
      check("t2 pop", 32'(q), 32'(exp2[i]));
    end

    // 3: replace keeps the pointer
    do_reset();
    op(1, 0, 0, 18'h3FFFF); check("t3 push", 32'(q), 32'h3FFFF);
    op(1, 1, 0, 18'h12345); check("t3 replace", 32'(q), 32'h12345);
    op(0, 1, 0, '0);        check("t3 pop", 32'(q), 32'h0);

    // 4: asynchronous reset during a push
    do_reset();
    op(1, 0, 0, 18'h00155);
    op(1, 0, 0, 18'h002AA); check("t4 before", 32'(q), 32'h2AA);
    push = 1'b1;
    d    = 18'h003AB;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t4 async q", 32'(q), 32'h0);
    @(posedge clk);
    #1;
    push = 1'b0;
    check("t4 held q", 32'(q), 32'h0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    op(0, 1, 0, '0);        check("t4 pop", 32'(q), 32'h0);

    // 5/6: watermark counter and flags (all zero in the plain build)
    do_reset();
    for (int v = 1; v <= 9; v++) op(1, 0, 0, W'(v));
    check("t5 depth full", 32'(depth), WM ? 32'd8 : 32'd0);
    check("t5 ovf", 32'(ovf), WM ? 32'd1 : 32'd0);
    check("t5 unf", 32'(unf), 32'd0);
    op(0, 0, 1, '0);
    check("t5 clr ovf", 32'(ovf), 32'd0);
    check("t5 clr depth", 32'(depth), 32'd0);
    check("t5 clr q", 32'(q), 32'd9);
    op(0, 1, 0, '0);
    check("t5 unf", 32'(unf), WM ? 32'd1 : 32'd0);
    check("t5 depth empty", 32'(depth), 32'd0);
    check("t5 q", 32'(q), 32'd8);

    // clr priority over a same-cycle overflow, then replace leaves depth alone
    do_reset();
    for (int v = 1; v <= 8; v++) op(1, 0, 0, W'(v));
    op(1, 0, 1, 18'h00AAA);
    check("clr prio ovf", 32'(ovf), 32'd0);
    check("clr prio depth", 32'(depth), 32'd0);
    check("clr prio q", 32'(q), 32'hAAA);
    op(1, 0, 0, 18'h00B01);
    op(1, 0, 0, 18'h00B02);
    op(1, 1, 0, 18'h00B03);
    check("replace depth", 32'(depth), WM ? 32'd2 : 32'd0);
    check("replace q", 32'(q), 32'hB03);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 60; i++) begin
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         ($urandom_range(0, 15) == 0), W'($urandom));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
